register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 9 +
 rtl/decoder_1to32.sv | 20 ++
 rtl/register_file.sv | 75 +++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing constants for the register file and its write-enable decoder.
// The optional forwarding feature is controlled by the REGISTER_FILE_BYPASS_EN macro.
package register_file_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_ADDR_BITS = 5;
    localparam int ZERO_REG          = 0;

endpackage

// File: rtl/decoder_1to32.sv
// Write-enable decoder: turns a write address plus enable into a one-hot entry-enable vector.
// Sized from ADDR_BITS; the default of 5 gives the 32-way decode the name refers to.
module decoder_1to32
    import register_file_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic [ADDR_BITS-1:0]    addr_i,
    input  logic                    en_i,
    output logic [2**ADDR_BITS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with entry 0 hardwired to zero and combinational reads.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegWrite,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DEPTH-1:0] writeEnable;
    logic [WIDTH-1:0] entries [DEPTH];
    logic [WIDTH-1:0] storedData1;
    logic [WIDTH-1:0] storedData2;
    logic             unusedZeroEnable;

    decoder_1to32 #(
        .ADDR_BITS (ADDR_BITS)
    ) u_decoder (
        .addr_i   (WriteRegister),
        .en_i     (RegWrite),
        .onehot_o (writeEnable)
    );

    // The zero entry has no storage, so its decoded enable has nowhere to go.
    assign unusedZeroEnable = writeEnable[ZERO_REG];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (i == ZERO_REG) begin : g_zero
            assign entries[i] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] entry_d;
            logic [WIDTH-1:0] entry_q;

            assign entry_d = writeEnable[i] ? WriteData : entry_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign entries[i] = entry_q;
        end
    end

    assign storedData1 = entries[ReadRegister1];
    assign storedData2 = entries[ReadRegister2];

`ifdef REGISTER_FILE_BYPASS_EN
    // Forward only writes that will actually land: not during reset and never to the zero entry.
    logic bypassValid;

    assign bypassValid = RegWrite && !rst && (WriteRegister != ADDR_BITS'(ZERO_REG));
    assign ReadData1   = (bypassValid && (WriteRegister == ReadRegister1)) ? WriteData : storedData1;
    assign ReadData2   = (bypassValid && (WriteRegister == ReadRegister2)) ? WriteData : storedData2;
`else
    assign ReadData1 = storedData1;
    assign ReadData2 = storedData2;
`endif

endmodule
